// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [6:0]  EXIT_OPCODE = 7'b1111111;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

endpackage

// File: rtl/pc_next_gen.sv
// Sequential PC and redirect-target generation, both wrapped to the imem size.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to load either result.
module pc_next_gen #(
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic [31:0] pc_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_next_o,
    output logic [31:0] redirect_tgt_o
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    // One extra bit so pc+4 at the top of the 32-bit space cannot alias low.
    logic [32:0] pc_plus4;
    logic [31:0] tgt_aligned;

    assign pc_plus4    = {1'b0, pc_i} + 33'd4;
    assign pc_next_o   = (pc_plus4 >= {1'b0, IMEM_BYTES}) ? 32'd0 : pc_plus4[31:0];

    // Both operands are word multiples, so the modulo result stays aligned.
    assign tgt_aligned    = redirect_pc_i & ~32'd3;
    assign redirect_tgt_o = tgt_aligned % IMEM_BYTES;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, captures imem data into IF/ID; optional halt via FETCH_HALT_EN.
// Latency: instruction at pc_o appears on ifid_* one cycle later; first valid capture 2 cycles after reset.
// Backpressure: stall_i holds PC, IF/ID and counter; redirect_i overrides stall and flushes IF/ID.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      pc_o,
    input  logic [31:0]      instr_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc_o,
    output logic             ifid_valid_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        ifid_pc_q, ifid_pc_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pc_next;
    logic [31:0]        redirect_tgt;

    pc_next_gen #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_pc_next_gen (
        .pc_i           (pc_q),
        .redirect_pc_i  (redirect_pc_i),
        .pc_next_o      (pc_next),
        .redirect_tgt_o (redirect_tgt)
    );

    // State, PC, IF/ID and counter registers; reset drops any in-flight fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            ifid_pc_q <= 32'd0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ifid_pc_q <= ifid_pc_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state: redirect beats stall beats a normal capture; HALT only drains IF/ID.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ifid_pc_d = ifid_pc_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    pc_d    = redirect_tgt;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (!stall_i) begin
                    instr_d   = instr_i;
                    ifid_pc_d = pc_q;
                    valid_d   = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    pc_d      = pc_next;
`ifdef FETCH_HALT_EN
                    // The exit word itself retires; fetch stops behind it.
                    if (instr_i[6:0] == EXIT_OPCODE) begin
                        state_d = HALT;
                    end
`endif
                end
            end
            HALT: begin
                if (!stall_i) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign pc_o         = pc_q;
    assign ifid_instr_o = instr_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_valid_o = valid_q;
    assign fetch_cnt_o  = cnt_q;

`ifdef FETCH_HALT_EN
    assign halted_o = (state_q == HALT);
`else
    assign halted_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a 1024-word instance plus an 8-word instance for wrap.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exit_en;

    logic [31:0] pc, instr, ifid_instr, ifid_pc, fetch_cnt;
    logic        ifid_valid, halted;
    logic [31:0] pc8, instr8, ifid_instr8, ifid_pc8, fetch_cnt8;
    logic        ifid_valid8, halted8;

    int n_vec = 0;
    int n_err = 0;

    // Memory model: word n holds n; optionally word 5 holds the exit opcode.
    assign instr  = (exit_en && pc == 32'h14) ? 32'h0000_007F : (pc >> 2);
    assign instr8 = pc8 >> 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(1024), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .pc_o(pc), .instr_i(instr),
        .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .ifid_instr_o(ifid_instr), .ifid_pc_o(ifid_pc), .ifid_valid_o(ifid_valid),
        .halted_o(halted), .fetch_cnt_o(fetch_cnt)
    );

    fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(8), .CNT_W(32)) dut8 (
        .clk(clk), .rst_n(rst_n), .pc_o(pc8), .instr_i(instr8),
        .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .ifid_instr_o(ifid_instr8), .ifid_pc_o(ifid_pc8), .ifid_valid_o(ifid_valid8),
        .halted_o(halted8), .fetch_cnt_o(fetch_cnt8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted for one edge, released 1 ns after a rising edge.
    task automatic apply_reset(input logic with_exit);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        exit_en     = with_exit;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; exit_en = 1'b0;
        #2;
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_vec++; if (ifid_instr !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instr: got %h want %h", ifid_instr, 32'h13); end
        n_vec++; if (ifid_pc !== 32'h0) begin n_err++; $display("FAIL reset_ifid_pc: got %h want 0", ifid_pc); end
        n_vec++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_vec++; if (fetch_cnt !== 32'h0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); end
        step();
        rst_n = 1'b1;
    endtask

    // Boot cycle, then words 0..3 at pc 0..0xC with the counter tracking.
    task automatic test_sequential();
        step();
        n_vec++; if (ifid_valid !== 1'b0 || pc !== 32'h0) begin n_err++; $display("FAIL boot_cycle: valid=%b pc=%h want valid=0 pc=0", ifid_valid, pc); end
        for (int n = 0; n < 4; n++) begin
            step();
            n_vec++;
            if (ifid_valid !== 1'b1 || ifid_instr !== 32'(n) || ifid_pc !== 32'(4*n) || fetch_cnt !== 32'(n+1)) begin
                n_err++;
                $display("FAIL seq_%0d: valid=%b instr=%h pc=%h cnt=%0d want 1 %h %h %0d",
                         n, ifid_valid, ifid_instr, ifid_pc, fetch_cnt, 32'(n), 32'(4*n), n+1);
            end
        end
        n_vec++; if (pc !== 32'h10) begin n_err++; $display("FAIL seq_pc: got %h want 10", pc); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (pc !== 32'h10 || ifid_instr !== 32'd3 || ifid_pc !== 32'h0C || fetch_cnt !== 32'd4 || ifid_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_%0d: pc=%h instr=%h ipc=%h cnt=%0d want 10 3 0c 4", k, pc, ifid_instr, ifid_pc, fetch_cnt);
            end
        end
        stall = 1'b0;
        step();
        n_vec++;
        if (ifid_instr !== 32'd4 || ifid_pc !== 32'h10 || fetch_cnt !== 32'd5 || pc !== 32'h14) begin
            n_err++;
            $display("FAIL stall_resume: instr=%h ipc=%h cnt=%0d pc=%h want 4 10 5 14", ifid_instr, ifid_pc, fetch_cnt, pc);
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h43;
        step();
        stall = 1'b0; redirect = 1'b0;
        n_vec++;
        if (pc !== 32'h40 || ifid_instr !== 32'h13 || ifid_valid !== 1'b0 || fetch_cnt !== 32'd5) begin
            n_err++;
            $display("FAIL redirect_flush: pc=%h instr=%h valid=%b cnt=%0d want 40 13 0 5", pc, ifid_instr, ifid_valid, fetch_cnt);
        end
        step();
        n_vec++;
        if (ifid_instr !== 32'd16 || ifid_pc !== 32'h40 || ifid_valid !== 1'b1 || fetch_cnt !== 32'd6) begin
            n_err++;
            $display("FAIL redirect_capture: instr=%h ipc=%h valid=%b cnt=%0d want 10 40 1 6", ifid_instr, ifid_pc, ifid_valid, fetch_cnt);
        end
        // Target beyond 4 KiB wraps modulo the memory size.
        redirect = 1'b1; redirect_pc = 32'h0000_1007;
        step();
        redirect = 1'b0;
        n_vec++; if (pc !== 32'h4) begin n_err++; $display("FAIL redirect_mod: got %h want 4", pc); end
    endtask

    task automatic test_wrap();
        apply_reset(1'b0);
        step();
        for (int n = 0; n < 8; n++) step();
        n_vec++;
        if (pc8 !== 32'h0 || ifid_pc8 !== 32'h1C || ifid_instr8 !== 32'd7) begin
            n_err++;
            $display("FAIL wrap_pc: pc=%h ipc=%h instr=%h want 0 1c 7", pc8, ifid_pc8, ifid_instr8);
        end
        step();
        n_vec++;
        if (ifid_instr8 !== 32'd0 || ifid_pc8 !== 32'h0 || fetch_cnt8 !== 32'd9) begin
            n_err++;
            $display("FAIL wrap_capture: instr=%h ipc=%h cnt=%0d want 0 0 9", ifid_instr8, ifid_pc8, fetch_cnt8);
        end
        redirect = 1'b1; redirect_pc = 32'h24;
        step();
        redirect = 1'b0;
        n_vec++; if (pc8 !== 32'h04) begin n_err++; $display("FAIL wrap_redirect: got %h want 04", pc8); end
    endtask

`ifdef FETCH_HALT_EN
    task automatic test_halt();
        apply_reset(1'b1);
        for (int n = 0; n < 7; n++) step();
        n_vec++;
        if (ifid_instr !== 32'h7F || ifid_valid !== 1'b1 || ifid_pc !== 32'h14) begin
            n_err++;
            $display("FAIL halt_exit: instr=%h valid=%b ipc=%h want 7f 1 14", ifid_instr, ifid_valid, ifid_pc);
        end
        step();
        n_vec++;
        if (halted !== 1'b1 || ifid_valid !== 1'b0 || pc !== 32'h18 || fetch_cnt !== 32'd6) begin
            n_err++;
            $display("FAIL halt_state: halted=%b valid=%b pc=%h cnt=%0d want 1 0 18 6", halted, ifid_valid, pc, fetch_cnt);
        end
        redirect = 1'b1; redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        n_vec++;
        if (halted !== 1'b1 || pc !== 32'h18) begin
            n_err++;
            $display("FAIL halt_ignore_redirect: halted=%b pc=%h want 1 18", halted, pc);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (halted !== 1'b0 || pc !== 32'h0) begin
            n_err++;
            $display("FAIL halt_reset: halted=%b pc=%h want 0 0", halted, pc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_halt_redirect_race();
        apply_reset(1'b1);
        for (int n = 0; n < 6; n++) step();
        n_vec++; if (pc !== 32'h14) begin n_err++; $display("FAIL race_setup: pc=%h want 14", pc); end
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        n_vec++;
        if (halted !== 1'b0 || pc !== 32'h40 || ifid_valid !== 1'b0) begin
            n_err++;
            $display("FAIL race_redirect: halted=%b pc=%h valid=%b want 0 40 0", halted, pc, ifid_valid);
        end
        step();
        n_vec++;
        if (halted !== 1'b0 || ifid_instr !== 32'd16 || ifid_valid !== 1'b1) begin
            n_err++;
            $display("FAIL race_continue: halted=%b instr=%h valid=%b want 0 10 1", halted, ifid_instr, ifid_valid);
        end
    endtask
`else
    task automatic test_exit_no_halt();
        apply_reset(1'b1);
        for (int n = 0; n < 7; n++) step();
        n_vec++;
        if (ifid_instr !== 32'h7F || ifid_valid !== 1'b1 || ifid_pc !== 32'h14) begin
            n_err++;
            $display("FAIL exit_fetch: instr=%h valid=%b ipc=%h want 7f 1 14", ifid_instr, ifid_valid, ifid_pc);
        end
        step();
        n_vec++;
        if (halted !== 1'b0 || ifid_instr !== 32'd6 || ifid_pc !== 32'h18 || ifid_valid !== 1'b1 || fetch_cnt !== 32'd7) begin
            n_err++;
            $display("FAIL exit_continue: halted=%b instr=%h ipc=%h valid=%b cnt=%0d want 0 6 18 1 7",
                     halted, ifid_instr, ifid_pc, ifid_valid, fetch_cnt);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; exit_en = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
`ifdef FETCH_HALT_EN
        test_halt();
        test_halt_redirect_race();
`else
        test_exit_no_halt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
